// File: rtl/tft_spi_rx_if.sv
// rtl/tft_spi_rx_if.sv - received-byte handshake between tft_spi_rx and its consumer
interface tft_spi_rx_if;
    logic [7:0] rx_data;
    logic       rx_rs;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_rs, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_rs, input rx_valid, output rx_ready);
endinterface

// File: rtl/tft_spi_rx.sv
// rtl/tft_spi_rx.sv - 3-wire TFT panel serial write receiver (start byte + data bytes)
module tft_spi_rx #(
    parameter logic DEV_ID = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         lcd_cs_i,
    input  logic         lcd_scl_i,
    input  logic         lcd_sda_i,
    tft_spi_rx_if.master rx,
    output logic         busy,
    output logic [7:0]   byte_cnt,
    output logic         frame_done,
    output logic         hdr_err,
    output logic         frame_err,
    output logic         overrun
);

    typedef enum logic [1:0] {IDLE, HDR, DATA, IGNORE} state_t;

    state_t     state_q, state_d;
    logic       cs_meta_q, cs_sync_q, cs_dly_q;
    logic       scl_meta_q, scl_sync_q, scl_dly_q;
    logic       sda_meta_q, sda_sync_q;
    logic [1:0] settle_q;
    logic [6:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_rs_q, rx_rs_d;
    logic       rx_valid_q, rx_valid_d;
    logic       frame_rs_q, frame_rs_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic       frame_done_q, frame_done_d;
    logic       hdr_err_q, hdr_err_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;
    logic       hdr_bad;

    logic       cs_fall, cs_rise, scl_rise, sample, settled, hdr_ok;
    logic [7:0] byte_full;

    assign cs_fall   = cs_dly_q & ~cs_sync_q;
    assign cs_rise   = ~cs_dly_q & cs_sync_q;
    assign scl_rise  = scl_sync_q & ~scl_dly_q;
    // An SCL edge coinciding with CS release still belongs to the frame.
    assign sample    = scl_rise & (~cs_sync_q | ~cs_dly_q);
    assign settled   = (settle_q == 2'd3);
    assign byte_full = {shift_q, sda_sync_q};
    assign hdr_ok    = (byte_full[7:3] == 5'b01110) && (byte_full[2] == DEV_ID) && !byte_full[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_meta_q    <= 1'b1;
            cs_sync_q    <= 1'b1;
            cs_dly_q     <= 1'b1;
            scl_meta_q   <= 1'b0;
            scl_sync_q   <= 1'b0;
            scl_dly_q    <= 1'b0;
            sda_meta_q   <= 1'b0;
            sda_sync_q   <= 1'b0;
            settle_q     <= 2'd0;
            state_q      <= IDLE;
            shift_q      <= 7'd0;
            bit_cnt_q    <= 3'd0;
            rx_data_q    <= 8'd0;
            rx_rs_q      <= 1'b0;
            rx_valid_q   <= 1'b0;
            frame_rs_q   <= 1'b0;
            byte_cnt_q   <= 8'd0;
            frame_done_q <= 1'b0;
            hdr_err_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            cs_meta_q    <= lcd_cs_i;
            cs_sync_q    <= cs_meta_q;
            cs_dly_q     <= cs_sync_q;
            scl_meta_q   <= lcd_scl_i;
            scl_sync_q   <= scl_meta_q;
            scl_dly_q    <= scl_sync_q;
            sda_meta_q   <= lcd_sda_i;
            sda_sync_q   <= sda_meta_q;
            if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_data_q    <= rx_data_d;
            rx_rs_q      <= rx_rs_d;
            rx_valid_q   <= rx_valid_d;
            frame_rs_q   <= frame_rs_d;
            byte_cnt_q   <= byte_cnt_d;
            frame_done_q <= frame_done_d;
            hdr_err_q    <= hdr_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        rx_data_d    = rx_data_q;
        rx_rs_d      = rx_rs_q;
        rx_valid_d   = rx_valid_q;
        frame_rs_d   = frame_rs_q;
        byte_cnt_d   = byte_cnt_q;
        frame_done_d = 1'b0;
        hdr_err_d    = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        hdr_bad      = 1'b0;

        if (rx_valid_q && rx.rx_ready) rx_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                // CS already low when the synchronizers settle: we joined mid-frame.
                if (!cs_sync_q && !settled) begin
                    state_d = IGNORE;
                end else if (cs_fall) begin
                    state_d    = HDR;
                    bit_cnt_d  = 3'd0;
                    shift_d    = 7'd0;
                    byte_cnt_d = 8'd0;
                end
            end
            HDR: begin
                if (sample) begin
                    shift_d   = byte_full[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (hdr_ok) begin
                            state_d    = DATA;
                            frame_rs_d = byte_full[1];
                        end else begin
                            state_d   = IGNORE;
                            hdr_err_d = 1'b1;
                            hdr_bad   = 1'b1;
                        end
                    end
                end
                if (cs_rise) begin
                    state_d = IDLE;
                    if (!hdr_bad) begin
                        frame_done_d = 1'b1;
                        frame_err_d  = (bit_cnt_d != 3'd0);
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shift_d   = byte_full[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (byte_cnt_q != 8'hFF) byte_cnt_d = byte_cnt_q + 8'd1;
                        if (!rx_valid_q || rx.rx_ready) begin
                            rx_data_d  = byte_full;
                            rx_rs_d    = frame_rs_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
                if (cs_rise) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                    frame_err_d  = (bit_cnt_d != 3'd0);
                end
            end
            IGNORE: begin
                if (cs_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx.rx_data  = rx_data_q;
    assign rx.rx_rs    = rx_rs_q;
    assign rx.rx_valid = rx_valid_q;
    assign busy        = (state_q != IDLE);
    assign byte_cnt    = byte_cnt_q;
    assign frame_done  = frame_done_q;
    assign hdr_err     = hdr_err_q;
    assign frame_err   = frame_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_tft_spi_rx.sv
// tb/tb_tft_spi_rx.sv - directed self-checking bench for tft_spi_rx with a byte scoreboard
module tb_tft_spi_rx;

    logic       clk;
    logic       rst_n;
    logic       cs, scl, sda;
    logic       busy;
    logic [7:0] byte_cnt;
    logic       frame_done, hdr_err, frame_err, overrun;

    tft_spi_rx_if bus ();

    tft_spi_rx #(.DEV_ID(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lcd_cs_i   (cs),
        .lcd_scl_i  (scl),
        .lcd_sda_i  (sda),
        .rx         (bus.master),
        .busy       (busy),
        .byte_cnt   (byte_cnt),
        .frame_done (frame_done),
        .hdr_err    (hdr_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       rs;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   tot_cnt  = 0;
    int   fd_n = 0, he_n = 0, fe_n = 0, ov_n = 0;
    int   fd0, he0, fe0, ov0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot_cnt = tot_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Accepted beats are compared against the queue; status pulses are counted.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_done) fd_n = fd_n + 1;
            if (hdr_err)    he_n = he_n + 1;
            if (frame_err)  fe_n = fe_n + 1;
            if (overrun)    ov_n = ov_n + 1;
            if (bus.rx_valid && bus.rx_ready) begin
                check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("beat_data", 32'(bus.rx_data), 32'(e.d));
                    check("beat_rs", 32'(bus.rx_rs), 32'(e.rs));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        fd0 = fd_n; he0 = he_n; fe0 = fe_n; ov0 = ov_n;
    endtask

    task automatic push(input logic [7:0] d, input logic rs);
        exp_t e;
        e.d = d; e.rs = rs;
        exp_q.push_back(e);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input int hp);
        for (int i = 7; i > 7 - n; i--) begin
            sda = b[i];
            scl = 1'b0;
            tick(hp);
            scl = 1'b1;
            tick(hp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hp);
        send_bits(b, 8, hp);
    endtask

    task automatic cs_low();
        scl = 1'b0;
        cs  = 1'b0;
        tick(4);
    endtask

    task automatic cs_high();
        scl = 1'b0;
        tick(4);
        cs = 1'b1;
        tick(8);
    endtask

    initial begin
        rst_n = 1'b0; cs = 1'b1; scl = 1'b0; sda = 1'b0;
        bus.rx_ready = 1'b1;
        tick(3);
        check("rst_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_data", 32'(bus.rx_data), 32'd0);
        check("rst_rs", 32'(bus.rx_rs), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
        rst_n = 1'b1;
        tick(4);

        // Two data bytes, RS = 1, SCL at clk/4
        snap();
        cs_low();
        send_byte(8'h72, 2);
        check("hdr_busy", 32'(busy), 32'd1);
        push(8'hA5, 1'b1); send_byte(8'hA5, 2);
        push(8'h3C, 1'b1); send_byte(8'h3C, 2);
        cs_high();
        check("f1_done", 32'(fd_n - fd0), 32'd1);
        check("f1_byte_cnt", 32'(byte_cnt), 32'd2);
        check("f1_hdr_err", 32'(he_n - he0), 32'd0);
        check("f1_frame_err", 32'(fe_n - fe0), 32'd0);
        check("f1_drained", 32'(exp_q.size()), 32'd0);
        check("f1_idle", 32'(busy), 32'd0);

        // Command byte, RS = 0
        snap();
        cs_low();
        send_byte(8'h70, 2);
        push(8'h11, 1'b0); send_byte(8'h11, 2);
        cs_high();
        check("f2_done", 32'(fd_n - fd0), 32'd1);
        check("f2_drained", 32'(exp_q.size()), 32'd0);

        // Read header and wrong-ID header are rejected
        snap();
        cs_low();
        send_byte(8'h73, 2);
        send_byte(8'h55, 2);
        check("rd_ignore_busy", 32'(busy), 32'd1);
        cs_high();
        cs_low();
        send_byte(8'h76, 2);
        send_byte(8'h55, 2);
        cs_high();
        check("badhdr_err", 32'(he_n - he0), 32'd2);
        check("badhdr_no_done", 32'(fd_n - fd0), 32'd0);
        check("badhdr_no_valid", 32'(bus.rx_valid), 32'd0);

        // Consumer stalled: second byte overruns, first byte held
        bus.rx_ready = 1'b0;
        snap();
        cs_low();
        send_byte(8'h72, 2);
        push(8'h01, 1'b1); send_byte(8'h01, 2);
        send_byte(8'h02, 2);
        cs_high();
        check("ov_pulse", 32'(ov_n - ov0), 32'd1);
        check("ov_byte_cnt", 32'(byte_cnt), 32'd2);
        check("ov_valid", 32'(bus.rx_valid), 32'd1);
        check("ov_data_held", 32'(bus.rx_data), 32'h01);
        check("ov_done", 32'(fd_n - fd0), 32'd1);

        // Header-only frame while a byte is still pending
        snap();
        cs_low();
        send_byte(8'h72, 2);
        cs_high();
        check("hdronly_done", 32'(fd_n - fd0), 32'd1);
        check("hdronly_byte_cnt", 32'(byte_cnt), 32'd0);
        check("hdronly_frame_err", 32'(fe_n - fe0), 32'd0);
        check("pending_valid", 32'(bus.rx_valid), 32'd1);
        check("pending_data", 32'(bus.rx_data), 32'h01);
        bus.rx_ready = 1'b1;
        tick(3);
        check("pending_cleared", 32'(bus.rx_valid), 32'd0);
        check("pending_drained", 32'(exp_q.size()), 32'd0);

        // Partial byte aborted, then a clean frame
        snap();
        cs_low();
        send_byte(8'h72, 2);
        send_bits(8'hA8, 5, 2);
        cs_high();
        check("part_frame_err", 32'(fe_n - fe0), 32'd1);
        check("part_done", 32'(fd_n - fd0), 32'd1);
        check("part_idle", 32'(busy), 32'd0);
        check("part_no_valid", 32'(bus.rx_valid), 32'd0);
        cs_low();
        send_byte(8'h72, 2);
        push(8'h5A, 1'b1); send_byte(8'h5A, 2);
        cs_high();
        check("part_next_drained", 32'(exp_q.size()), 32'd0);
        check("part_next_byte_cnt", 32'(byte_cnt), 32'd1);

        // SCL at clk/8
        snap();
        cs_low();
        send_byte(8'h72, 4);
        push(8'hFF, 1'b1); send_byte(8'hFF, 4);
        cs_high();
        check("slow_drained", 32'(exp_q.size()), 32'd0);
        check("slow_done", 32'(fd_n - fd0), 32'd1);

        // SCL at clk/4
        cs_low();
        send_byte(8'h72, 2);
        push(8'hFF, 1'b1); send_byte(8'hFF, 2);
        cs_high();
        check("fast_drained", 32'(exp_q.size()), 32'd0);

        // Reset released with CS already low: whole frame ignored
        rst_n = 1'b0; cs = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(6);
        check("join_ignore_busy", 32'(busy), 32'd1);
        snap();
        send_byte(8'h72, 2);
        send_byte(8'h33, 2);
        check("join_no_valid", 32'(bus.rx_valid), 32'd0);
        check("join_no_hdr_err", 32'(he_n - he0), 32'd0);
        cs_high();
        check("join_idle", 32'(busy), 32'd0);
        check("join_no_done", 32'(fd_n - fd0), 32'd0);

        // Reset asserted mid-byte with a byte pending
        bus.rx_ready = 1'b0;
        snap();
        cs_low();
        send_byte(8'h72, 2);
        send_byte(8'h99, 2);
        tick(4);
        check("mid_valid", 32'(bus.rx_valid), 32'd1);
        check("mid_data", 32'(bus.rx_data), 32'h99);
        check("mid_byte_cnt", 32'(byte_cnt), 32'd1);
        send_bits(8'hF0, 4, 2);
        rst_n = 1'b0;
        tick(1);
        check("mid_rst_valid", 32'(bus.rx_valid), 32'd0);
        check("mid_rst_data", 32'(bus.rx_data), 32'd0);
        check("mid_rst_byte_cnt", 32'(byte_cnt), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        cs = 1'b1; scl = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(6);
        check("mid_no_frame_err", 32'(fe_n - fe0), 32'd0);
        check("mid_no_done", 32'(fd_n - fd0), 32'd0);
        bus.rx_ready = 1'b1;
        tick(4);
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
